// File: rtl/pair_batch_if.sv
// Load and batch-output bundle of the pairwise-distance batch streamer.
// master = streamer side, slave = upstream loader / downstream batch consumer side.
interface pair_batch_if #(
    parameter int unsigned MAX_NODE_COUNT  = 2000,
    parameter int unsigned COORD_BIT_WIDTH = 12,
    parameter int unsigned DIMENSIONS      = 3,
    parameter int unsigned BATCH_SIZE      = 16
);
    localparam int unsigned INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT);

    logic                                                        load_valid;
    logic [DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0]                  load_coords;
    logic                                                        load_last;
    logic                                                        load_ready;
    logic                                                        out_ready;
    logic [BATCH_SIZE-1:0][DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0]  batch_coords;
    logic [BATCH_SIZE-1:0][INDEX_BIT_WIDTH-1:0]                  batch_indices;
    logic [BATCH_SIZE-1:0]                                       batch_valid;
    logic                                                        batch_line_end;
    logic                                                        batch_stream_end;

    modport master (
        input  load_valid, load_coords, load_last, out_ready,
        output load_ready, batch_coords, batch_indices, batch_valid,
               batch_line_end, batch_stream_end
    );

    modport slave (
        output load_valid, load_coords, load_last, out_ready,
        input  load_ready, batch_coords, batch_indices, batch_valid,
               batch_line_end, batch_stream_end
    );
endinterface

// File: rtl/pair_batch_streamer.sv
// Buffers a point list, then sweeps each reference i against points i..N-1 as BATCH_SIZE-wide beats.
// Optional beat/stall statistics counters are built when PAIR_BATCH_STATS_EN is defined.
module pair_batch_streamer #(
    parameter  int unsigned MAX_NODE_COUNT  = 2000,
    parameter  int unsigned COORD_BIT_WIDTH = 12,
    parameter  int unsigned DIMENSIONS      = 3,
    parameter  int unsigned BATCH_SIZE      = 16,
    localparam int unsigned INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    pair_batch_if.master               bus,
    input  logic                       restart,
    input  logic                       clear,
    output logic [INDEX_BIT_WIDTH-1:0] point_count,
    output logic [31:0]                beat_count,
    output logic [31:0]                stall_count
);
    localparam int unsigned IW = INDEX_BIT_WIDTH;
    localparam int unsigned EW = IW + $clog2(BATCH_SIZE + 1) + 1;

    typedef logic [DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0] point_t;
    typedef enum logic [1:0] {ST_LOAD, ST_SWEEP, ST_DONE} state_t;

    state_t                                 state_q, state_d;
    logic [IW-1:0]                          count_q, count_d;
    logic [IW-1:0]                          ref_q, ref_d;
    logic [IW-1:0]                          col_q, col_d;
    logic                                   load_ready_q, load_ready_d;
    point_t [BATCH_SIZE-1:0]                bcoords_q, bcoords_d;
    logic [BATCH_SIZE-1:0][IW-1:0]          bidx_q, bidx_d;
    logic [BATCH_SIZE-1:0]                  bvalid_q, bvalid_d;
    logic                                   ble_q, ble_d;
    logic                                   bse_q, bse_d;

    point_t                                 mem_q [MAX_NODE_COUNT];

    logic                                   wr_en;
    logic                                   last_c;
    logic                                   xfer;
    logic                                   build_en;
    logic                                   bypass_en;
    logic [IW-1:0]                          build_ref;
    logic [IW-1:0]                          build_col;
    logic [IW-1:0]                          build_n;
    logic [EW-1:0]                          slot_e;
    point_t [BATCH_SIZE-1:0]                beat_coords;
    logic [BATCH_SIZE-1:0][IW-1:0]          beat_idx;
    logic [BATCH_SIZE-1:0]                  beat_valid;
    logic                                   beat_le;
    logic                                   beat_se;

    assign wr_en  = (state_q == ST_LOAD) && bus.load_valid;
    assign last_c = wr_en && (bus.load_last || (count_q == IW'(MAX_NODE_COUNT - 1)));
    assign xfer   = (|bvalid_q) && bus.out_ready;

    // Point storage; no reset, the list is invalidated through count_q.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[count_q] <= bus.load_coords;
        end
    end

    // Selects which (ref, col) beat, if any, gets loaded into the output registers this edge.
    always_comb begin
        build_en  = 1'b0;
        bypass_en = 1'b0;
        build_ref = '0;
        build_col = '0;
        build_n   = count_q;
        unique case (state_q)
            ST_LOAD: begin
                if (last_c) begin
                    build_en  = 1'b1;
                    bypass_en = 1'b1;
                    build_n   = count_q + 1'b1;
                end
            end
            ST_SWEEP: begin
                if (xfer && !bse_q) begin
                    build_en = 1'b1;
                    if (ble_q) begin
                        build_ref = ref_q + 1'b1;
                        build_col = ref_q + 1'b1;
                    end else begin
                        build_ref = ref_q;
                        build_col = col_q + IW'(BATCH_SIZE);
                    end
                end
            end
            ST_DONE: begin
                build_en = restart && !clear;
            end
            default: ;
        endcase
    end

    // Beat formation; the point written on the final load edge is forwarded from load_coords.
    always_comb begin
        beat_coords = '0;
        beat_idx    = '0;
        beat_valid  = '0;
        slot_e      = '0;
        for (int unsigned s = 0; s < BATCH_SIZE; s++) begin
            slot_e = EW'(build_col) + EW'(s);
            if (slot_e < EW'(build_n)) begin
                beat_valid[s] = 1'b1;
                beat_idx[s]   = slot_e[IW-1:0];
                if (bypass_en && (slot_e[IW-1:0] == count_q)) begin
                    beat_coords[s] = bus.load_coords;
                end else begin
                    beat_coords[s] = mem_q[slot_e[IW-1:0]];
                end
            end
        end
        beat_le = (EW'(build_col) + EW'(BATCH_SIZE)) >= EW'(build_n);
        beat_se = beat_le && ((EW'(build_ref) + EW'(2)) >= EW'(build_n));
    end

    // Next-state and registered outputs.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        ref_d     = ref_q;
        col_d     = col_q;
        bcoords_d = bcoords_q;
        bidx_d    = bidx_q;
        bvalid_d  = bvalid_q;
        ble_d     = ble_q;
        bse_d     = bse_q;
        unique case (state_q)
            ST_LOAD: begin
                if (wr_en) begin
                    count_d = count_q + 1'b1;
                    if (last_c) begin
                        state_d = ST_SWEEP;
                    end
                end
            end
            ST_SWEEP: begin
                if (xfer && bse_q) begin
                    state_d   = ST_DONE;
                    bcoords_d = '0;
                    bidx_d    = '0;
                    bvalid_d  = '0;
                    ble_d     = 1'b0;
                    bse_d     = 1'b0;
                end
            end
            ST_DONE: begin
                if (clear) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                end else if (restart) begin
                    state_d = ST_SWEEP;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
        if (build_en) begin
            ref_d     = build_ref;
            col_d     = build_col;
            bcoords_d = beat_coords;
            bidx_d    = beat_idx;
            bvalid_d  = beat_valid;
            ble_d     = beat_le;
            bse_d     = beat_se;
        end
        load_ready_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_LOAD;
            count_q      <= '0;
            ref_q        <= '0;
            col_q        <= '0;
            load_ready_q <= 1'b1;
            bcoords_q    <= '0;
            bidx_q       <= '0;
            bvalid_q     <= '0;
            ble_q        <= 1'b0;
            bse_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            ref_q        <= ref_d;
            col_q        <= col_d;
            load_ready_q <= load_ready_d;
            bcoords_q    <= bcoords_d;
            bidx_q       <= bidx_d;
            bvalid_q     <= bvalid_d;
            ble_q        <= ble_d;
            bse_q        <= bse_d;
        end
    end

    assign bus.load_ready       = load_ready_q;
    assign bus.batch_coords     = bcoords_q;
    assign bus.batch_indices    = bidx_q;
    assign bus.batch_valid      = bvalid_q;
    assign bus.batch_line_end   = ble_q;
    assign bus.batch_stream_end = bse_q;
    assign point_count          = count_q;

`ifdef PAIR_BATCH_STATS_EN
    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Counters restart with every accepted restart/clear so each sweep is measured on its own.
    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_DONE) && (restart || clear)) begin
            beat_cnt_d  = '0;
            stall_cnt_d = '0;
        end else begin
            if (xfer) begin
                beat_cnt_d = beat_cnt_q + 32'd1;
            end
            if ((state_q == ST_SWEEP) && (|bvalid_q) && !bus.out_ready) begin
                stall_cnt_d = stall_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            beat_cnt_q  <= beat_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign beat_count  = beat_cnt_q;
    assign stall_count = stall_cnt_q;
`else
    assign beat_count  = '0;
    assign stall_count = '0;
`endif
endmodule

// File: tb/tb_pair_batch_streamer.sv
// Self-checking bench: dut_a (BATCH_SIZE=4) via scenario table + scoreboard,
// dut_b (MAX_NODE_COUNT=40, BATCH_SIZE=16) for the storage-full forced sweep.
module tb_pair_batch_streamer;
    localparam int unsigned IW_A = 11;
    localparam int unsigned IW_B = 6;

    typedef logic [2:0][11:0] pt_t;

    typedef struct {
        logic [3:0][IW_A-1:0] idx;
        pt_t  [3:0]           crd;
        logic [3:0]           vld;
        logic                 le;
        logic                 se;
    } beat_t;

    typedef struct {
        int   i0, i1, i2, i3;
        logic [3:0] v;
        logic le, se;
    } vec_t;

    typedef struct {
        int n;
        bit toggle;
        bit restart_only;
        int exp_beats;
        int exp_stalls;
    } scen_t;

    logic clk, rst_n;
    logic a_restart, a_clear, b_restart, b_clear;
    logic [IW_A-1:0] a_count;
    logic [IW_B-1:0] b_count;
    logic [31:0] a_beats, a_stalls, b_beats_o, b_stalls_o;

    pair_batch_if #(.MAX_NODE_COUNT(2000), .COORD_BIT_WIDTH(12), .DIMENSIONS(3), .BATCH_SIZE(4)) a_if ();
    pair_batch_if #(.MAX_NODE_COUNT(40), .COORD_BIT_WIDTH(12), .DIMENSIONS(3), .BATCH_SIZE(16)) b_if ();

    pair_batch_streamer #(.MAX_NODE_COUNT(2000), .COORD_BIT_WIDTH(12), .DIMENSIONS(3), .BATCH_SIZE(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(a_if), .restart(a_restart), .clear(a_clear),
        .point_count(a_count), .beat_count(a_beats), .stall_count(a_stalls)
    );

    pair_batch_streamer #(.MAX_NODE_COUNT(40), .COORD_BIT_WIDTH(12), .DIMENSIONS(3), .BATCH_SIZE(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(b_if), .restart(b_restart), .clear(b_clear),
        .point_count(b_count), .beat_count(b_beats_o), .stall_count(b_stalls_o)
    );

    int    n_chk  = 0;
    int    n_pass = 0;
    beat_t sb[$];
    bit    mon_en = 1'b0;
    bit    hold_chk = 1'b0;
    logic [193:0] hold_snap;
    beat_t e;
    vec_t  tv[5];
    scen_t sc[4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic pt_t coord_of(input int i);
        pt_t p;
        for (int d = 0; d < 3; d++) p[d] = 12'(i * 37 + d * 500 + 5);
        return p;
    endfunction

    task automatic push_model(input int n);
        int last_ref;
        beat_t b;
        last_ref = (n == 1) ? 0 : n - 2;
        for (int r = 0; r <= last_ref; r++) begin
            for (int c = r; c < n; c += 4) begin
                b.idx = '0; b.crd = '0; b.vld = '0;
                for (int s = 0; s < 4; s++) begin
                    if (c + s < n) begin
                        b.vld[s] = 1'b1;
                        b.idx[s] = IW_A'(c + s);
                        b.crd[s] = coord_of(c + s);
                    end
                end
                b.le = (c + 4 >= n);
                b.se = b.le && (r == last_ref);
                sb.push_back(b);
            end
        end
    endtask

    task automatic push_table();
        beat_t b;
        int    ix[4];
        for (int j = 0; j < 5; j++) begin
            ix[0] = tv[j].i0; ix[1] = tv[j].i1; ix[2] = tv[j].i2; ix[3] = tv[j].i3;
            b.crd = '0;
            for (int s = 0; s < 4; s++) begin
                b.idx[s] = IW_A'(ix[s]);
                if (tv[j].v[s]) b.crd[s] = coord_of(ix[s]);
            end
            b.vld = tv[j].v;
            b.le  = tv[j].le;
            b.se  = tv[j].se;
            sb.push_back(b);
        end
    endtask

    // Scoreboard monitor for dut_a, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en && (a_if.batch_valid != '0)) begin
            if (hold_chk) begin
                chk("hold_stable", 256'({a_if.batch_coords, a_if.batch_indices, a_if.batch_valid,
                                         a_if.batch_line_end, a_if.batch_stream_end}), 256'(hold_snap));
                hold_chk = 1'b0;
            end
            if (a_if.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", 256'(a_if.batch_valid), 256'(0));
                end else begin
                    e = sb.pop_front();
                    chk("beat_idx", 256'(a_if.batch_indices), 256'(e.idx));
                    chk("beat_valid", 256'(a_if.batch_valid), 256'(e.vld));
                    chk("beat_coords", 256'(a_if.batch_coords), 256'(e.crd));
                    chk("beat_ends", 256'({a_if.batch_line_end, a_if.batch_stream_end}), 256'({e.le, e.se}));
                end
            end else begin
                hold_snap = {a_if.batch_coords, a_if.batch_indices, a_if.batch_valid,
                             a_if.batch_line_end, a_if.batch_stream_end};
                hold_chk  = 1'b1;
            end
        end
    end

    task automatic load_a(input int n, input bit last, input bit push);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            a_if.load_valid  = 1'b1;
            a_if.load_coords = coord_of(i);
            a_if.load_last   = last && (i == n - 1);
            if (push && last && (i == n - 1)) push_model(n);
        end
        @(posedge clk); #1;
        a_if.load_valid = 1'b0;
        a_if.load_last  = 1'b0;
    endtask

    task automatic run_sweep(input bit toggle, output int cyc);
        cyc = 0;
        a_if.out_ready = 1'b1;
        @(negedge clk);
        chk("first_beat_present", 256'(a_if.batch_valid != '0), 256'(1));
        do begin
            @(posedge clk); #1;
            a_if.out_ready = toggle ? ~a_if.out_ready : 1'b1;
            cyc++;
        end while (sb.size() != 0 && cyc < 200);
        if (sb.size() != 0) begin
            chk("sweep_timeout", 256'(sb.size()), 256'(0));
            sb.delete();
        end
    endtask

    task automatic do_clear();
        @(posedge clk); #1;
        a_clear = 1'b1; a_restart = 1'b1;
        @(posedge clk); #1;
        a_clear = 1'b0; a_restart = 1'b0;
        @(negedge clk);
        chk("clear_load_ready", 256'(a_if.load_ready), 256'(1));
        chk("clear_point_count", 256'(a_count), 256'(0));
        chk("clear_no_beat", 256'(a_if.batch_valid), 256'(0));
        @(posedge clk); #1;
        a_restart = 1'b1;
        @(posedge clk); #1;
        a_restart = 1'b0;
        @(negedge clk);
        chk("restart_ignored_in_load", 256'({a_if.load_ready, a_if.batch_valid}), 256'({1'b1, 4'b0000}));
    endtask

    initial begin
        int cyc, b_ref, b_col, b_first, b_total, b_exp_total;
        logic [15:0] m;
        logic le_e, se_e;
        bit done;

        tv[0] = '{0, 1, 2, 3, 4'b1111, 1'b0, 1'b0};
        tv[1] = '{4, 0, 0, 0, 4'b0001, 1'b1, 1'b0};
        tv[2] = '{1, 2, 3, 4, 4'b1111, 1'b1, 1'b0};
        tv[3] = '{2, 3, 4, 0, 4'b0111, 1'b1, 1'b0};
        tv[4] = '{3, 4, 0, 0, 4'b0011, 1'b1, 1'b1};
        sc[0] = '{5, 1'b0, 1'b0, 5, 0};
        sc[1] = '{5, 1'b1, 1'b1, 5, 4};
        sc[2] = '{5, 1'b0, 1'b1, 5, 0};
        sc[3] = '{1, 1'b0, 1'b0, 1, 0};

        a_if.load_valid = 1'b0; a_if.load_coords = '0; a_if.load_last = 1'b0; a_if.out_ready = 1'b0;
        b_if.load_valid = 1'b0; b_if.load_coords = '0; b_if.load_last = 1'b0; b_if.out_ready = 1'b0;
        a_restart = 1'b0; a_clear = 1'b0; b_restart = 1'b0; b_clear = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_load_ready", 256'(a_if.load_ready), 256'(1));
        chk("rst_point_count", 256'(a_count), 256'(0));
        chk("rst_batch", 256'({a_if.batch_valid, a_if.batch_line_end, a_if.batch_stream_end}), 256'(0));
        chk("rst_batch_data", 256'({a_if.batch_coords, a_if.batch_indices}), 256'(0));
        chk("rst_stats", 256'({a_beats, a_stalls}), 256'(0));
        #9 rst_n = 1'b1;
        mon_en = 1'b1;

        for (int k = 0; k < 4; k++) begin
            if (!sc[k].restart_only && k > 0) do_clear();
            if (sc[k].restart_only) begin
                @(posedge clk); #1;
                a_restart = 1'b1;
                push_model(sc[k].n);
                @(posedge clk); #1;
                a_restart = 1'b0;
            end else begin
                load_a(sc[k].n, 1'b1, k != 0);
                if (k == 0) push_table();
            end
            run_sweep(sc[k].toggle, cyc);
            chk("sweep_cycles", 256'(cyc), 256'(sc[k].toggle ? 2 * sc[k].exp_beats - 1 : sc[k].exp_beats));
            @(negedge clk);
            chk("done_outputs", 256'({a_if.batch_valid, a_if.batch_line_end, a_if.batch_stream_end}), 256'(0));
            chk("done_point_count", 256'(a_count), 256'(sc[k].n));
            chk("done_load_ready", 256'(a_if.load_ready), 256'(0));
`ifdef PAIR_BATCH_STATS_EN
            chk("stat_beats", 256'(a_beats), 256'(sc[k].exp_beats));
            chk("stat_stalls", 256'(a_stalls), 256'(sc[k].exp_stalls));
`else
            chk("stat_tied_off", 256'({a_beats, a_stalls}), 256'(0));
`endif
        end

        // Reset in the middle of the third beat of a fresh sweep.
        do_clear();
        mon_en = 1'b0;
        load_a(5, 1'b1, 1'b0);
        a_if.out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #3;
        chk("pre_reset_third_beat", 256'(a_if.batch_indices[0]), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("async_rst_batch", 256'({a_if.batch_valid, a_if.batch_line_end, a_if.batch_stream_end}), 256'(0));
        chk("async_rst_data", 256'({a_if.batch_coords, a_if.batch_indices}), 256'(0));
        chk("async_rst_state", 256'({a_if.load_ready, a_count}), 256'({1'b1, 11'd0}));
        #3 rst_n = 1'b1;
        mon_en = 1'b1;
        load_a(3, 1'b1, 1'b1);
        run_sweep(1'b0, cyc);
        chk("reload3_cycles", 256'(cyc), 256'(2));

        // dut_b: fill storage without load_last; the last write forces the sweep.
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            b_if.load_valid  = 1'b1;
            b_if.load_coords = coord_of(i);
        end
        @(posedge clk); #1;
        b_if.load_valid = 1'b0;
        b_if.out_ready  = 1'b1;
        @(negedge clk);
        chk("b_forced_sweep", 256'({b_if.load_ready, b_count, b_if.batch_valid != '0}), 256'({1'b0, 6'd40, 1'b1}));
        b_exp_total = 0;
        for (int i = 0; i <= 38; i++) b_exp_total += (40 - i + 15) / 16;
        b_ref = 0; b_col = 0; b_first = 0; b_total = 0; done = 1'b0;
        for (int c = 0; c < 3000 && !done; c++) begin
            if (b_if.batch_valid != '0) begin
                m = '0;
                for (int s = 0; s < 16; s++) if (b_col + s < 40) m[s] = 1'b1;
                le_e = (b_col + 16 >= 40);
                se_e = le_e && (b_ref == 38);
                chk("b_beat", 256'({b_if.batch_valid, b_if.batch_line_end, b_if.batch_stream_end, b_if.batch_indices[0]}),
                    256'({m, le_e, se_e, IW_B'(b_col)}));
                b_total++;
                if (b_ref == 0) b_first++;
                if (b_if.batch_stream_end) begin
                    chk("b_last_valid", 256'(b_if.batch_valid), 256'(16'h0003));
                    done = 1'b1;
                end
                if (le_e) begin
                    if (b_ref == 0) chk("b_first_line_beats", 256'(b_first), 256'(3));
                    b_ref++;
                    b_col = b_ref;
                end else begin
                    b_col += 16;
                end
            end
            @(negedge clk);
        end
        if (!done) chk("b_timeout", 256'(0), 256'(1));
        chk("b_total_beats", 256'(b_total), 256'(b_exp_total));
        chk("b_done_outputs", 256'({b_if.batch_valid, b_if.batch_stream_end}), 256'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
